// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared definitions for the time-set controller: FSM state
//               encoding, display edit-field codes and time-field limits.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    localparam logic [1:0] c_edit_none    = 2'b00;
    localparam logic [1:0] c_edit_hours   = 2'b01;
    localparam logic [1:0] c_edit_minutes = 2'b10;

    localparam logic [4:0] MAX_HOURS   = 5'd23;
    localparam logic [5:0] MAX_MINUTES = 6'd59;

    // Display blink code for the field being edited in a given state.
    function automatic logic [1:0] edit_code(input state_t s);
        case (s)
            ST_SET_HR:  edit_code = c_edit_hours;
            ST_SET_MIN: edit_code = c_edit_minutes;
            default:    edit_code = c_edit_none;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge
// Description : Rising-edge detector for a synchronous button level.
//               pulse = level & ~previous_sample.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               i_level - button level (already synchronous)
//               o_pulse - one-cycle pulse on a 0->1 transition
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;

    // Previous sample resets to 1 so a button held through reset release
    // does not look like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_pulse = i_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Two-button time-setting controller. MODE walks
//               RUN -> SET_HR -> SET_MIN -> COMMIT -> RUN, INC bumps the field
//               being edited. COMMIT pulses load for one cycle. An idle
//               timeout abandons the edit without loading.
// Ports       : Clk_1sec     - 1 Hz clock
//               reset        - asynchronous active-low reset
//               mode_btn     - mode button level
//               inc_btn      - increment button level
//               cur_hours    - live hours (captured on entering edit)
//               cur_minutes  - live minutes (captured on entering edit)
//               count_en     - clock counter may advance
//               load         - one-cycle load strobe
//               load_hours   - hours to load (shadow register)
//               load_minutes - minutes to load (shadow register)
//               load_seconds - seconds to load, constant 0
//               edit_field   - 00 none, 01 hours, 10 minutes
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic       Clk_1sec,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic       count_en,
    output logic       load,
    output logic [4:0] load_hours,
    output logic [5:0] load_minutes,
    output logic [5:0] load_seconds,
    output logic [1:0] edit_field
);

    localparam int              IDLE_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(TIMEOUT - 1);

    logic              w_mode_edge;
    logic              w_inc_edge;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_hr;
    logic [4:0]        w_hr_nxt;
    logic [5:0]        r_min;
    logic [5:0]        w_min_nxt;
    logic [IDLE_W-1:0] r_idle;
    logic [IDLE_W-1:0] w_idle_nxt;

    btn_edge u_mode_edge (
        .clk     (Clk_1sec),
        .rst_n   (reset),
        .i_level (mode_btn),
        .o_pulse (w_mode_edge)
    );

    btn_edge u_inc_edge (
        .clk     (Clk_1sec),
        .rst_n   (reset),
        .i_level (inc_btn),
        .o_pulse (w_inc_edge)
    );

    // Next-state logic. The idle counter defaults to 0, so it clears on any
    // edge and outside the set states; it only advances on a quiet set cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hr_nxt    = r_hr;
        w_min_nxt   = r_min;
        w_idle_nxt  = '0;
        case (r_state)
            ST_RUN: begin
                if (w_mode_edge) begin
                    w_hr_nxt    = cur_hours;
                    w_min_nxt   = cur_minutes;
                    w_state_nxt = ST_SET_HR;
                end
            end
            ST_SET_HR: begin
                if (w_mode_edge) begin
                    w_state_nxt = ST_SET_MIN;
                end else if (w_inc_edge) begin
                    // >= also wraps an out-of-range captured value to 0
                    w_hr_nxt = (r_hr >= MAX_HOURS) ? 5'd0 : r_hr + 5'd1;
                end else if (r_idle == c_idle_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_idle_nxt = r_idle + 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (w_mode_edge) begin
                    w_state_nxt = ST_COMMIT;
                end else if (w_inc_edge) begin
                    w_min_nxt = (r_min >= MAX_MINUTES) ? 6'd0 : r_min + 6'd1;
                end else if (r_idle == c_idle_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_idle_nxt = r_idle + 1'b1;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State, shadows and outputs are all registered; outputs are computed
    // from the next state so they line up with the state they describe.
    always_ff @(posedge Clk_1sec or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_hr       <= '0;
            r_min      <= '0;
            r_idle     <= '0;
            count_en   <= 1'b1;
            load       <= 1'b0;
            edit_field <= c_edit_none;
        end else begin
            r_state    <= w_state_nxt;
            r_hr       <= w_hr_nxt;
            r_min      <= w_min_nxt;
            r_idle     <= w_idle_nxt;
            count_en   <= (w_state_nxt == ST_RUN);
            load       <= (w_state_nxt == ST_COMMIT);
            edit_field <= edit_code(w_state_nxt);
        end
    end

    assign load_hours   = r_hr;
    assign load_minutes = r_min;
    assign load_seconds = 6'd0;

endmodule
`default_nettype wire
